grn_result_collector: RTL and testbench

// Shares the single 512-bit host write path between BLOCKS_NUMBER grn engines.
// A round-robin arbiter picks one finished engine per cycle and packs its (transient, conf) pair into a 512-bit line.

---
 rtl/grn_pkg.sv | 19 +
 rtl/grn_rr_arbiter.sv | 54 +++++
 rtl/grn_result_collector.sv | 118 +++++++++++
 tb/tb_grn_result_collector.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grn_pkg.sv
// Shared types for the grn result collection path.
// Line geometry and the (transient, conf) pair layout.
package grn_pkg;

  localparam int LINE_W         = 512;
  localparam int WORD_W         = 32;
  localparam int PAIRS_PER_LINE = 8;
  localparam int PAIR_W         = 2 * WORD_W;
  localparam int CNT_W          = 4;

  typedef logic [LINE_W-1:0] t_line;

  // conf sits in the upper word of each 64-bit pair slot
  typedef struct packed {
    logic [WORD_W-1:0] conf;
    logic [WORD_W-1:0] transient;
  } t_pair;

endpackage

// File: rtl/grn_rr_arbiter.sv
// Round-robin arbiter: first unmasked requester at or after the pointer.
// The pointer moves past the winner on every issued grant.
module grn_rr_arbiter #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic                 enable,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] index,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [N-1:0]  elig;
  logic          found;

  assign elig = req & ~mask;

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    index = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && elig[j]) begin
        found = 1'b1;
        index = IW'(j);
      end
    end
  end

  assign valid = found && enable;

  always_comb begin
    grant = '0;
    if (valid) grant[index] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (index == IW'(N - 1)) ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/grn_result_collector.sv
// Fair collector packing grn engine results into 512-bit host lines.
// Assembly buffer feeds a 1-deep req/ack output stage.
import grn_pkg::*;

module grn_result_collector #(
  parameter int BLOCKS_NUMBER = 16,
  parameter int CONF_W        = 69
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BLOCKS_NUMBER-1:0]        blk_done,
  input  logic [32*BLOCKS_NUMBER-1:0]     blk_transient,
  input  logic [CONF_W*BLOCKS_NUMBER-1:0] blk_conf,
  output logic [BLOCKS_NUMBER-1:0]        blk_ack,
  input  logic                            flush,
  output logic                            wr_req,
  output logic [LINE_W-1:0]               wr_data,
  output logic [3:0]                      wr_words,
  input  logic                            wr_ack,
  output logic                            idle
);

  localparam int IW = $clog2(BLOCKS_NUMBER);

  logic [BLOCKS_NUMBER-1:0] grant;
  logic [IW-1:0]            gidx;
  logic                     gvalid;

  t_line            asm_q, asm_d, line_d;
  logic [CNT_W-1:0] count, count_d, words_d;
  logic             flush_pend, flush_pend_d;

  logic              full, out_free, enable;
  logic              flush_any;
  logic              promote_full, promote_flush, promote;
  logic [CONF_W-1:0] conf_sel;
  logic [WORD_W-1:0] tr_sel;
  logic              unused_conf_hi;
  t_pair             pair;

  assign full     = (count == CNT_W'(PAIRS_PER_LINE));
  assign out_free = !wr_req || wr_ack;
  assign enable   = !full || out_free;

  grn_rr_arbiter #(.N(BLOCKS_NUMBER)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (blk_done),
    .mask   (blk_ack),
    .enable (enable),
    .grant  (grant),
    .index  (gidx),
    .valid  (gvalid)
  );

  assign conf_sel       = blk_conf[gidx*CONF_W +: CONF_W];
  assign tr_sel         = blk_transient[gidx*WORD_W +: WORD_W];
  assign unused_conf_hi = ^conf_sel[CONF_W-1:WORD_W];
  assign pair           = '{conf: conf_sel[WORD_W-1:0], transient: tr_sel};

  assign flush_any     = flush || flush_pend;
  assign promote_full  = full && out_free;
  assign promote_flush = flush_any && (count != '0) && !full && out_free;
  assign promote       = promote_full || promote_flush;

  always_comb begin
    asm_d   = asm_q;
    count_d = count;
    if (promote_full) begin
      asm_d   = '0;
      count_d = '0;
    end
    // a same-cycle grant lands in the next free slot of the (possibly cleared) buffer
    if (gvalid) begin
      asm_d[{count_d[2:0], 6'd0} +: PAIR_W] = pair;
      count_d = count_d + 1'b1;
    end
    line_d  = promote_full ? asm_q : asm_d;
    words_d = promote_full ? count : count_d;
    if (promote_flush) begin
      asm_d   = '0;
      count_d = '0;
    end
  end

  always_comb begin
    flush_pend_d = flush_pend;
    if (promote)
      flush_pend_d = 1'b0;
    else if (flush && (count != '0))
      flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q      <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
      blk_ack    <= '0;
      wr_req     <= 1'b0;
      wr_data    <= '0;
      wr_words   <= '0;
    end else begin
      asm_q      <= asm_d;
      count      <= count_d;
      flush_pend <= flush_pend_d;
      blk_ack    <= grant;
      wr_req     <= promote || (wr_req && !wr_ack);
      if (promote) begin
        wr_data  <= line_d;
        wr_words <= words_d;
      end
    end
  end

  assign idle = (count == '0) && !wr_req && !(|blk_done) && !flush_pend;

endmodule

// File: tb/tb_grn_result_collector.sv
// Directed and randomized bench for grn_result_collector.
// Engines and host are modelled as a pair scoreboard in ack order.
module tb_grn_result_collector;

  localparam int N  = 16;
  localparam int CW = 69;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    blk_done;
  logic [32*N-1:0] blk_transient;
  logic [CW*N-1:0] blk_conf;
  logic [N-1:0]    blk_ack;
  logic            flush;
  logic            wr_req;
  logic [511:0]    wr_data;
  logic [3:0]      wr_words;
  logic            wr_ack;
  logic            idle;

  int errors = 0;
  int checks = 0;

  logic [31:0]   tr [N];
  logic [CW-1:0] cf [N];
  int            remaining [N];
  logic [63:0]   expq [$];
  int            ack_total;
  logic [N-1:0]  one_hot;

  grn_result_collector #(.BLOCKS_NUMBER(N), .CONF_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .blk_done      (blk_done),
    .blk_transient (blk_transient),
    .blk_conf      (blk_conf),
    .blk_ack       (blk_ack),
    .flush         (flush),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .wr_words      (wr_words),
    .wr_ack        (wr_ack),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_data(int i);
    tr[i] = $urandom;
    cf[i] = {5'($urandom), $urandom, $urandom};
  endtask

  task automatic raise(int i, int n);
    remaining[i] = n;
    new_data(i);
    blk_done[i] = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      blk_transient[i*32 +: 32] = tr[i];
      blk_conf[i*CW +: CW]      = cf[i];
    end
  endtask

  task automatic check_line();
    chk("line_words_range", 512'(wr_words >= 4'd1 && wr_words <= 4'd8), 1);
    for (int k = 0; k < 8; k++) begin
      if (k < int'(wr_words)) begin
        chk("line_underflow", 512'(expq.size() > 0), 1);
        if (expq.size() > 0)
          chk("line_pair", wr_data[64*k +: 64], expq.pop_front());
      end else begin
        chk("line_zero_pad", wr_data[64*k +: 64], 0);
      end
    end
  endtask

  task automatic tick();
    drive();
    if (wr_req && wr_ack) check_line();
    @(posedge clk);
    #1;
    chk("ack_onehot", 512'($onehot0(blk_ack)), 1);
    for (int i = 0; i < N; i++) begin
      if (blk_ack[i]) begin
        ack_total++;
        chk("ack_pending", 512'(remaining[i] > 0), 1);
        expq.push_back({cf[i][31:0], tr[i]});
        remaining[i]--;
        if (remaining[i] > 0) new_data(i);
        else blk_done[i] = 1'b0;
      end
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    one_hot   = 1;
    ack_total = 0;
    rst       = 1'b1;
    blk_done  = '0;
    flush     = 1'b0;
    wr_ack    = 1'b0;
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0;
      new_data(i);
    end
    drive();
    #3;
    chk("rst_wr_req", 512'(wr_req), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_words", 512'(wr_words), 0);
    chk("rst_blk_ack", 512'(blk_ack), 0);
    chk("rst_idle", 512'(idle), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // all engines done at once
    wr_ack = 1'b1;
    for (int i = 0; i < N; i++) raise(i, 1);
    for (int k = 0; k < N; k++) begin
      tick();
      chk("t1_ack_order", 512'(blk_ack), 512'(one_hot << k));
      if (k == 8) chk("t1_words", 512'(wr_words), 8);
    end
    repeat (4) tick();
    chk("t1_drained", 512'(expq.size()), 0);
    chk("t1_idle", 512'(idle), 1);

    // single engine re-raising
    raise(5, 6);
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("t2_ack5", 512'(blk_ack[5]), 512'(t % 2 == 1));
    end
    pulse_flush();
    chk("t2_req", 512'(wr_req), 1);
    chk("t2_words", 512'(wr_words), 6);
    tick();
    chk("t2_req_clear", 512'(wr_req), 0);

    // partial line flush, then empty flush
    for (int i = 1; i <= 3; i++) raise(i, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t3_ack_order", 512'(blk_ack), 512'(one_hot << i));
    end
    pulse_flush();
    chk("t3_req", 512'(wr_req), 1);
    chk("t3_words", 512'(wr_words), 3);
    chk("t3_pad", 512'(wr_data[511:192]), 0);
    tick();
    pulse_flush();
    chk("t3_empty_flush", 512'(wr_req), 0);
    tick();
    chk("t3_empty_flush2", 512'(wr_req), 0);
    chk("t3_idle", 512'(idle), 1);

    // backpressure with 20 results pending
    wr_ack    = 1'b0;
    ack_total = 0;
    for (int i = 0; i < N; i++) raise(i, (i < 4) ? 2 : 1);
    repeat (30) tick();
    chk("t4_acks", 512'(ack_total), 16);
    chk("t4_stall", 512'(blk_ack), 0);
    chk("t4_req", 512'(wr_req), 1);
    chk("t4_words", 512'(wr_words), 8);
    wr_ack = 1'b1;
    repeat (20) tick();
    chk("t4_total", 512'(ack_total), 20);
    pulse_flush();
    repeat (3) tick();
    chk("t4_drained", 512'(expq.size()), 0);
    chk("t4_idle", 512'(idle), 1);

    // grant and flush together at count 7
    ack_total = 0;
    for (int i = 0; i < 8; i++) raise(i, 1);
    for (int t = 0; t < 20 && ack_total < 7; t++) tick();
    chk("t5_seven", 512'(ack_total), 7);
    pulse_flush();
    chk("t5_ack8", 512'(ack_total), 8);
    chk("t5_req", 512'(wr_req), 1);
    chk("t5_words", 512'(wr_words), 8);
    tick();
    chk("t5_drained", 512'(expq.size()), 0);
    chk("t5_idle", 512'(idle), 1);

    // asynchronous reset with data in flight
    wr_ack    = 1'b0;
    ack_total = 0;
    for (int i = 0; i < 13; i++) raise(i, 1);
    for (int t = 0; t < 40 && ack_total < 13; t++) tick();
    chk("t6_thirteen", 512'(ack_total), 13);
    chk("t6_req", 512'(wr_req), 1);
    chk("t6_busy", 512'(idle), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_wr_req", 512'(wr_req), 0);
    chk("t6_wr_data", wr_data, 0);
    chk("t6_wr_words", 512'(wr_words), 0);
    chk("t6_blk_ack", 512'(blk_ack), 0);
    chk("t6_idle_rst", 512'(idle), 1);
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_idle", 512'(idle), 1);
    wr_ack = 1'b1;
    raise(9, 1);
    tick();
    chk("t6_ack9", 512'(blk_ack), 512'(one_hot << 9));
    pulse_flush();
    chk("t6_words", 512'(wr_words), 1);
    tick();
    chk("t6_drained", 512'(expq.size()), 0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (remaining[i] == 0 && !blk_done[i] && $urandom_range(0, 7) == 0)
          raise(i, int'($urandom_range(1, 3)));
      wr_ack = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      tick();
      flush = 1'b0;
    end
    wr_ack = 1'b1;
    for (int t = 0; t < 200 && !(idle && expq.size() == 0); t++) begin
      if (t % 4 == 0) pulse_flush();
      else tick();
    end
    chk("t7_drained", 512'(expq.size()), 0);
    chk("t7_idle", 512'(idle), 1);
    chk("t7_done_clear", 512'(blk_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
